scene_timer_controller: RTL and testbench

//  Sequences the operator inputs from the input wrapper into a scene-monitor countdown timer (minutes:seconds).
//  - Synchronises and debounces the four push keys.
//  - Runs a set/load/arm/run/pause FSM and builds load values from the two BCD switch groups.
//  - Generates the timer tick at real or demo rate.

---
 rtl/scene_timer_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_scene_timer_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/scene_timer_controller.sv
// scene_timer_controller: operator-key sequencer for the scene-monitor countdown timer.
// Synchronises and debounces the four active-low keys, runs the set/load/arm/run/pause
// FSM, builds BCD load values and generates the decrement tick at real or demo rate.
// Optional feature macro: BCD_CHECK_EN (reject loads with tens > 5 or ones > 9).
module scene_timer_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEB_W           = 18,
    parameter int REAL_TICK_DIV   = 50000000,
    parameter int DEMO_TICK_DIV   = 50000,
    parameter int TICK_W          = 26
) (
    input  logic       clkIn,
    input  logic       resetIn,
    input  logic [3:0] resetSetLoadStartIn,
    input  logic [3:0] toggleSwitches17To14In,
    input  logic [3:0] toggleSwitches13To10In,
    input  logic       demoOrRealModeIn,
    input  logic       monitorOrMissedSceneIn,
    output logic [2:0] stateOut,
    output logic       loadEnOut,
    output logic       loadFieldOut,
    output logic [7:0] loadValueOut,
    output logic       tickOut,
    output logic       runningOut,
    output logic       softResetOut,
    output logic       errorOut
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SET_MIN = 3'd1;
    localparam logic [2:0] S_SET_SEC = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_PAUSE   = 3'd5;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] REAL_LAST = TICK_W'(REAL_TICK_DIV - 1);
    localparam logic [TICK_W-1:0] DEMO_LAST = TICK_W'(DEMO_TICK_DIV - 1);

    logic [3:0]            key_s1_q, key_s2_q;
    logic                  demo_s1_q, demo_s2_q, demo_s3_q;
    logic                  mon_s1_q, mon_s2_q;
    logic [3:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]            deb_lvl_q, deb_lvl_d, deb_prev_q;
    logic [3:0]            press;
    logic                  p_rst, p_set, p_load, p_start;
    logic [2:0]            state_q, state_d;
    logic                  load_en_q, load_en_d;
    logic                  load_field_q, load_field_d;
    logic [7:0]            load_val_q, load_val_d, sw_val;
    logic                  soft_q, soft_d;
    logic                  running_q, running_d;
    logic [TICK_W-1:0]     pre_q, pre_d, div_last;
    logic                  tick_q, tick_d;
    logic                  load_ok;
`ifdef BCD_CHECK_EN
    logic                  err_q, err_d;
`endif

    // Two-flop synchronisers; demo gets a third stage so a level change can be seen
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            demo_s1_q <= 1'b0;
            demo_s2_q <= 1'b0;
            demo_s3_q <= 1'b0;
            mon_s1_q  <= 1'b0;
            mon_s2_q  <= 1'b0;
        end else begin
            key_s1_q  <= resetSetLoadStartIn;
            key_s2_q  <= key_s1_q;
            demo_s1_q <= demoOrRealModeIn;
            demo_s2_q <= demo_s1_q;
            demo_s3_q <= demo_s2_q;
            mon_s1_q  <= monitorOrMissedSceneIn;
            mon_s2_q  <= mon_s1_q;
        end
    end

    // Per-key debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        for (int k = 0; k < 4; k++) begin
            if (key_s2_q[k] != deb_lvl_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    deb_lvl_d[k] = key_s2_q[k];
                    deb_cnt_d[k] = '0;
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
                end
            end else begin
                deb_cnt_d[k] = '0;
            end
        end
    end

    // Debounce state and previous level for edge detection
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            deb_cnt_q  <= '0;
            deb_lvl_q  <= '0;
            deb_prev_q <= '0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            deb_prev_q <= deb_lvl_q;
        end
    end

    // Keys are active-low: a press is a debounced 1->0 edge; priority reset > set > load > start
    assign press   = deb_prev_q & ~deb_lvl_q;
    assign p_rst   = press[3];
    assign p_set   = press[2] & ~press[3];
    assign p_load  = press[1] & ~|press[3:2];
    assign p_start = press[0] & ~|press[3:1];

    assign sw_val = ({4'd0, toggleSwitches17To14In} * 8'd10) + {4'd0, toggleSwitches13To10In};
`ifdef BCD_CHECK_EN
    assign load_ok = (toggleSwitches17To14In <= 4'd5) && (toggleSwitches13To10In <= 4'd9);
`else
    assign load_ok = 1'b1;
`endif

    // Sequencer next state and strobes
    always_comb begin
        state_d      = state_q;
        load_en_d    = 1'b0;
        load_field_d = load_field_q;
        load_val_d   = load_val_q;
        soft_d       = 1'b0;
`ifdef BCD_CHECK_EN
        err_d        = 1'b0;
`endif
        if (p_rst) begin
            soft_d  = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (p_set) state_d = S_SET_MIN;
                S_SET_MIN: begin
                    if (p_set) state_d = S_SET_SEC;
                    else if (p_load) begin
                        if (load_ok) begin
                            load_en_d    = 1'b1;
                            load_field_d = 1'b0;
                            load_val_d   = sw_val;
                            state_d      = S_SET_SEC;
                        end
`ifdef BCD_CHECK_EN
                        else err_d = 1'b1;
`endif
                    end
                end
                S_SET_SEC: begin
                    if (p_set) state_d = S_SET_MIN;
                    else if (p_load) begin
                        if (load_ok) begin
                            load_en_d    = 1'b1;
                            load_field_d = 1'b1;
                            load_val_d   = sw_val;
                            state_d      = S_ARMED;
                        end
`ifdef BCD_CHECK_EN
                        else err_d = 1'b1;
`endif
                    end
                end
                S_ARMED: begin
                    if (p_set) state_d = S_SET_MIN;
                    else if (p_start && mon_s2_q) state_d = S_RUN;
                end
                S_RUN:     if (p_start || !mon_s2_q) state_d = S_PAUSE;
                S_PAUSE: begin
                    if (p_set) state_d = S_SET_MIN;
                    else if (p_start && mon_s2_q) state_d = S_RUN;
                end
                default:   state_d = S_IDLE;
            endcase
        end
        running_d = (state_d == S_RUN);
    end

    // Prescaler: counts in RUN, holds in PAUSE, clears elsewhere and on any rate change
    always_comb begin
        div_last = demo_s2_q ? DEMO_LAST : REAL_LAST;
        pre_d    = pre_q;
        tick_d   = 1'b0;
        if (p_rst || (demo_s2_q != demo_s3_q)) begin
            pre_d = '0;
        end else if (state_q == S_RUN) begin
            if (pre_q == div_last) begin
                tick_d = 1'b1;
                pre_d  = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end else if (state_q != S_PAUSE) begin
            pre_d = '0;
        end
    end

    // Registered state, prescaler and outputs
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q      <= S_IDLE;
            load_en_q    <= 1'b0;
            load_field_q <= 1'b0;
            load_val_q   <= '0;
            soft_q       <= 1'b0;
            running_q    <= 1'b0;
            pre_q        <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_en_q    <= load_en_d;
            load_field_q <= load_field_d;
            load_val_q   <= load_val_d;
            soft_q       <= soft_d;
            running_q    <= running_d;
            pre_q        <= pre_d;
            tick_q       <= tick_d;
        end
    end

`ifdef BCD_CHECK_EN
    // Invalid-load strobe
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign errorOut = err_q;
`else
    assign errorOut = 1'b0;
`endif

    assign stateOut     = state_q;
    assign loadEnOut    = load_en_q;
    assign loadFieldOut = load_field_q;
    assign loadValueOut = load_val_q;
    assign tickOut      = tick_q;
    assign runningOut   = running_q;
    assign softResetOut = soft_q;

endmodule

// File: tb/tb_scene_timer_controller.sv
// tb_scene_timer_controller: directed bench for scene_timer_controller with short
// debounce (4) and tick dividers (demo 8, real 20).
module tb_scene_timer_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'hF;
    logic [3:0] tens = 4'd0, ones = 4'd0;
    logic       demo = 1'b1, mon = 1'b0;
    logic [2:0] stateOut;
    logic       loadEnOut, loadFieldOut, tickOut, runningOut, softResetOut, errorOut;
    logic [7:0] loadValueOut;

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_load = 0, n_tick = 0, n_soft = 0, n_err = 0, n_chg = 0;
    int last_tick = 0, last_iv = 0;
    logic       last_field = 1'b0;
    logic [7:0] last_val = 8'd0;
    logic [2:0] prev_state = 3'd0;
    int snap, snap2;

    scene_timer_controller #(
        .DEBOUNCE_CYCLES(4), .DEB_W(18), .REAL_TICK_DIV(20), .DEMO_TICK_DIV(8), .TICK_W(26)
    ) dut (
        .clkIn(clk), .resetIn(rst), .resetSetLoadStartIn(keys),
        .toggleSwitches17To14In(tens), .toggleSwitches13To10In(ones),
        .demoOrRealModeIn(demo), .monitorOrMissedSceneIn(mon),
        .stateOut(stateOut), .loadEnOut(loadEnOut), .loadFieldOut(loadFieldOut),
        .loadValueOut(loadValueOut), .tickOut(tickOut), .runningOut(runningOut),
        .softResetOut(softResetOut), .errorOut(errorOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (loadEnOut) begin
            n_load++;
            last_field = loadFieldOut;
            last_val   = loadValueOut;
        end
        if (tickOut) begin
            last_iv   = cyc - last_tick;
            last_tick = cyc;
            n_tick++;
        end
        if (softResetOut) n_soft++;
        if (errorOut) n_err++;
        if (stateOut != prev_state) n_chg++;
        prev_state = stateOut;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the masked keys low long enough to debounce, then release and let it settle
    task automatic press(input logic [3:0] mask);
        keys = 4'hF & ~mask;
        cycles(12);
        keys = 4'hF;
        cycles(12);
    endtask

    initial begin
        // 1. reset state and reset mid-debounce
        cycles(3);
        chk("reset_state", {29'd0, stateOut}, 32'd0);
        chk("reset_outputs", {15'd0, stateOut, loadEnOut, loadFieldOut, loadValueOut,
                              tickOut, runningOut, softResetOut, errorOut}, 32'd0);
        rst = 1'b0;
        cycles(12);
        keys = 4'b1011;
        cycles(4);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(10);
        keys = 4'hF;
        cycles(12);
        chk("mid_debounce_state", {29'd0, stateOut}, 32'd0);
        chk("mid_debounce_soft", n_soft, 0);

        // 2. bouncing set key, then held: exactly one IDLE -> SET_MIN
        snap = n_chg;
        for (int i = 0; i < 10; i++) begin
            keys[2] = ~keys[2];
            cycles(2);
        end
        press(4'b0100);
        chk("bounce_state", {29'd0, stateOut}, 32'd1);
        chk("bounce_transitions", n_chg - snap, 1);

        // 3. minutes 45, seconds 30
        tens = 4'd4; ones = 4'd5;
        snap = n_load;
        press(4'b0010);
        chk("load_min_count", n_load - snap, 1);
        chk("load_min_field", {31'd0, last_field}, 32'd0);
        chk("load_min_value", {24'd0, last_val}, 32'd45);
        chk("load_min_state", {29'd0, stateOut}, 32'd2);
        tens = 4'd3; ones = 4'd0;
        press(4'b0010);
        chk("load_sec_count", n_load - snap, 2);
        chk("load_sec_field", {31'd0, last_field}, 32'd1);
        chk("load_sec_value", {24'd0, last_val}, 32'd30);
        chk("load_sec_state", {29'd0, stateOut}, 32'd3);

        // 4. start inhibited in review mode, then run at demo and real rate, then pause
        press(4'b0001);
        chk("start_inhibited", {29'd0, stateOut}, 32'd3);
        mon = 1'b1;
        cycles(5);
        press(4'b0001);
        chk("run_state", {29'd0, stateOut}, 32'd4);
        chk("run_running", {31'd0, runningOut}, 32'd1);
        cycles(40);
        chk("demo_tick_interval", last_iv, 8);
        demo = 1'b0;
        cycles(70);
        chk("real_tick_interval", last_iv, 20);
        mon = 1'b0;
        cycles(10);
        chk("pause_state", {29'd0, stateOut}, 32'd5);
        chk("pause_running", {31'd0, runningOut}, 32'd0);
        snap = n_tick;
        cycles(50);
        chk("pause_no_ticks", n_tick - snap, 0);
        mon = 1'b1;
        cycles(5);
        press(4'b0001);
        chk("resume_state", {29'd0, stateOut}, 32'd4);

        // 6. reset key and start key in the same cycle while running
        snap2 = n_soft;
        press(4'b1001);
        chk("softreset_one_cycle", n_soft - snap2, 1);
        chk("softreset_state", {29'd0, stateOut}, 32'd0);
        chk("softreset_running", {31'd0, runningOut}, 32'd0);
        chk("softreset_tick", {31'd0, tickOut}, 32'd0);
        snap = n_tick;
        cycles(30);
        chk("softreset_no_ticks", n_tick - snap, 0);

        // 5. out-of-range BCD load, then boundary 5/9
        press(4'b0100);
        chk("set_min_again", {29'd0, stateOut}, 32'd1);
        tens = 4'd7; ones = 4'd2;
        snap = n_load; snap2 = n_err;
`ifdef BCD_CHECK_EN
        press(4'b0010);
        chk("bcd_err_pulse", n_err - snap2, 1);
        chk("bcd_err_noload", n_load - snap, 0);
        chk("bcd_err_state", {29'd0, stateOut}, 32'd1);
        tens = 4'd5; ones = 4'd9;
        press(4'b0010);
        chk("bcd_edge_value", {24'd0, last_val}, 32'd59);
        chk("bcd_edge_state", {29'd0, stateOut}, 32'd2);
`else
        press(4'b0010);
        chk("raw_load_count", n_load - snap, 1);
        chk("raw_load_value", {24'd0, last_val}, 32'd72);
        chk("raw_load_state", {29'd0, stateOut}, 32'd2);
        chk("raw_no_error", n_err - snap2, 0);
        tens = 4'd5; ones = 4'd9;
        press(4'b0010);
        chk("edge_value", {24'd0, last_val}, 32'd59);
        chk("edge_state", {29'd0, stateOut}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
